// File: rtl/table3x4_pkg.sv
// Shared constants and types for the 3x4 table writer and its companions.
package table3x4_pkg;

    localparam int TBL_ROWS    = 3;
    localparam int TBL_COLS    = 4;
    localparam int TBL_ENTRIES = TBL_ROWS * TBL_COLS;

    // Value the selector returns for an unaddressable entry.
    localparam logic [31:0] TBL_INVALID = 32'hDEAD_BEEF;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    typedef logic [3:0] clr_cnt_t;
    typedef logic [1:0] row_idx_t;
    typedef logic [1:0] col_t;

    localparam clr_cnt_t CLR_LAST = clr_cnt_t'(TBL_ENTRIES - 1);

    // Row-major flat index; with four columns this is simply {row, col}.
    function automatic clr_cnt_t entry_idx(input row_idx_t row, input col_t col);
        return {row, col};
    endfunction

endpackage

// File: rtl/table3x4_row_dec.sv
// Priority decode of the one-hot row field to a row index plus valid flag.
// Define TABLE3X4_WR_ONEHOT_CHECK_EN to reject rows that are not exactly one-hot.
module table3x4_row_dec
    import table3x4_pkg::*;
(
    input  logic [2:0] row,
    output row_idx_t   row_idx,
    output logic       row_valid
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        row_idx   = '0;
        row_valid = 1'b0;
        if (row[0]) begin
            row_idx   = 2'd0;
            row_valid = 1'b1;
        end else if (row[1]) begin
            row_idx   = 2'd1;
            row_valid = 1'b1;
        end else if (row[2]) begin
            row_idx   = 2'd2;
            row_valid = 1'b1;
        end
`ifdef TABLE3X4_WR_ONEHOT_CHECK_EN
        if (!$onehot(row)) begin
            row_valid = 1'b0;
        end
`else
`endif
    end

endmodule

// File: rtl/table3x4_wr.sv
// Write side of the 3x4 table: 12 x 32-bit entries, byte-enabled writes, sequential clear.
// Optional strict one-hot row check via TABLE3X4_WR_ONEHOT_CHECK_EN (in table3x4_row_dec).
module table3x4_wr
    import table3x4_pkg::*;
#(
    parameter logic [31:0] INIT_VAL = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        res_n,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [1:0]  wr_col,
    input  logic [2:0]  wr_row,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_be,
    input  logic        clr_req,
    output logic        clr_busy,
    output logic        err,
    output logic [31:0] out_0x0,
    output logic [31:0] out_0x1,
    output logic [31:0] out_0x2,
    output logic [31:0] out_0x3,
    output logic [31:0] out_1x0,
    output logic [31:0] out_1x1,
    output logic [31:0] out_1x2,
    output logic [31:0] out_1x3,
    output logic [31:0] out_2x0,
    output logic [31:0] out_2x1,
    output logic [31:0] out_2x2,
    output logic [31:0] out_2x3
);

    state_t      state_q;
    clr_cnt_t    cnt_q;
    logic [31:0] mem [TBL_ENTRIES];

    row_idx_t    row_idx;
    logic        row_valid;
    logic        wr_fire;
    clr_cnt_t    wr_idx;

    table3x4_row_dec u_row_dec (
        .row       (wr_row),
        .row_idx   (row_idx),
        .row_valid (row_valid)
    );

    // A clear request in IDLE takes priority over a write offered in the same cycle.
    assign wr_ready = (state_q == IDLE) && !clr_req;
    assign clr_busy = (state_q == CLEAR);
    assign wr_fire  = wr_valid && wr_ready;
    assign wr_idx   = entry_idx(row_idx, wr_col);

    always_ff @(posedge clk) begin
        if (!res_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err     <= 1'b0;
            // NOTE: the table itself is reset because reset must restore INIT_VAL, not just control state.
            for (int i = 0; i < TBL_ENTRIES; i++) begin
                mem[i] <= INIT_VAL;
            end
        end else begin
            err <= wr_fire && !row_valid;
            unique case (state_q)
                IDLE: begin
                    if (clr_req) begin
                        state_q <= CLEAR;
                        cnt_q   <= '0;
                    end else if (wr_fire && row_valid) begin
                        for (int b = 0; b < 4; b++) begin
                            if (wr_be[b]) begin
                                mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                            end
                        end
                    end
                end
                CLEAR: begin
                    mem[cnt_q] <= INIT_VAL;
                    if (cnt_q == CLR_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + clr_cnt_t'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_0x0 = mem[0];
    assign out_0x1 = mem[1];
    assign out_0x2 = mem[2];
    assign out_0x3 = mem[3];
    assign out_1x0 = mem[4];
    assign out_1x1 = mem[5];
    assign out_1x2 = mem[6];
    assign out_1x3 = mem[7];
    assign out_2x0 = mem[8];
    assign out_2x1 = mem[9];
    assign out_2x2 = mem[10];
    assign out_2x3 = mem[11];

endmodule
